// File: rtl/mandel_pixel_sequencer.sv
// Frame-level sequencer for the Mandelbrot render path: scans pixels in raster
// order, runs the iteration engine per pixel, feeds the color converter and
// hands each RGB pixel to the frame-buffer writer over valid/ready.
module mandel_pixel_sequencer #(
    parameter int unsigned WIDTH  = 160,
    parameter int unsigned HEIGHT = 120,
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic              eng_start,
    output logic [9:0]        eng_x,
    output logic [8:0]        eng_y,
    input  logic              eng_done,
    input  logic [7:0]        eng_iter,
    input  logic              eng_inset,
    output logic [7:0]        cc_iteration,
    output logic              cc_ismandelbrot,
    input  logic [23:0]       cc_rgb,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [23:0]       pix_rgb
);

    localparam int unsigned X_W = 10;
    localparam int unsigned Y_W = 9;
    localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        CONVERT = 3'd3,
        WRITE   = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ADDR_W-1:0] addr;
    logic              last_pix;
    logic              latch_eng;
    logic              latch_pix;
    logic              advance;
    logic              clear_pos;

    assign last_pix = (x == X_LAST) && (y == Y_LAST);

    // The engine sees the current scan position directly; it only moves on a handshake.
    assign eng_x = x;
    assign eng_y = y;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-cycle datapath strobes.
    always_comb begin
        state_next = state;
        latch_eng  = 1'b0;
        latch_pix  = 1'b0;
        advance    = 1'b0;
        clear_pos  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (eng_done) begin
                    latch_eng  = 1'b1;
                    state_next = CONVERT;
                end
            end
            CONVERT: begin
                latch_pix  = 1'b1;
                state_next = WRITE;
            end
            WRITE: begin
                if (pix_ready) begin
                    if (last_pix) begin
                        state_next = DONE;
                    end else begin
                        advance    = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            DONE: begin
                clear_pos  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control outputs registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            frame_done <= 1'b0;
            eng_start  <= 1'b0;
            pix_valid  <= 1'b0;
        end else begin
            busy       <= (state_next != IDLE);
            frame_done <= (state_next == DONE);
            eng_start  <= (state_next == ISSUE);
            pix_valid  <= (state_next == WRITE);
        end
    end

    // Raster position and running linear address (no multiplier needed).
    always_ff @(posedge clk) begin
        if (rst || clear_pos) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (advance) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= y + Y_W'(1);
            end else begin
                x <= x + X_W'(1);
            end
            addr <= addr + ADDR_W'(1);
        end
    end

    // Engine result capture toward the color converter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cc_iteration    <= '0;
            cc_ismandelbrot <= 1'b0;
        end else if (latch_eng) begin
            cc_iteration    <= eng_iter;
            cc_ismandelbrot <= eng_inset;
        end
    end

    // Pixel payload capture; held steady through the whole write handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_addr <= '0;
            pix_rgb  <= '0;
        end else if (latch_pix) begin
            pix_addr <= addr;
            pix_rgb  <= cc_rgb;
        end
    end

endmodule

// File: tb/tb_mandel_pixel_sequencer.sv
// Bench for mandel_pixel_sequencer on a 4x2 frame: engine, color converter and
// frame-buffer writer models, with a raster-order reference for every pixel.
`timescale 1ns/1ps
module tb_mandel_pixel_sequencer;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned HEIGHT = 2;
    localparam int unsigned ADDR_W = 3;
    localparam int          NPIX   = WIDTH * HEIGHT;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy;
    logic              frame_done;
    logic              eng_start;
    logic [9:0]        eng_x;
    logic [8:0]        eng_y;
    logic              eng_done;
    logic [7:0]        eng_iter;
    logic              eng_inset;
    logic [7:0]        cc_iteration;
    logic              cc_ismandelbrot;
    logic [23:0]       cc_rgb;
    logic              pix_valid;
    logic              pix_ready;
    logic [ADDR_W-1:0] pix_addr;
    logic [23:0]       pix_rgb;

    mandel_pixel_sequencer #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .busy           (busy),
        .frame_done     (frame_done),
        .eng_start      (eng_start),
        .eng_x          (eng_x),
        .eng_y          (eng_y),
        .eng_done       (eng_done),
        .eng_iter       (eng_iter),
        .eng_inset      (eng_inset),
        .cc_iteration   (cc_iteration),
        .cc_ismandelbrot(cc_ismandelbrot),
        .cc_rgb         (cc_rgb),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_addr       (pix_addr),
        .pix_rgb        (pix_rgb)
    );

    // Grey-scale converter: in-set points are black.
    assign cc_rgb = cc_ismandelbrot ? 24'h000000 : {cc_iteration, cc_iteration, cc_iteration};

    always #5 clk = ~clk;

    // lat: 0 = random 1..20; stall_pix: -1 none, -2 random ready; inset: -1 none, -3 random pixel
    typedef struct {
        int lat;
        int stall_pix;
        int stall_len;
        int inset;
        bit rand_seed;
        bit spur;
        bit abuse;
        int exp_cycles;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    int n_vec = 0;
    int n_err = 0;

    int cfg_lat;
    int cfg_stall_pix;
    int cfg_inset;
    bit cfg_spur;
    int seed;
    int stall_left;

    int rem;
    int cur_idx;
    int exp_issue;
    int exp_wr;
    bit pend;
    int fd_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_iter(input int idx);
        if (idx == cfg_inset) return 8'd200;
        return 8'(idx + seed);
    endfunction

    function automatic logic [23:0] exp_rgb(input int idx);
        logic [7:0] it;
        if (idx == cfg_inset) return 24'h000000;
        it = exp_iter(idx);
        return {it, it, it};
    endfunction

    // Engine model, writer model and raster-order scoreboard, all away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            rem       = 0;
            eng_done  = 1'b0;
            pend      = 1'b0;
            exp_issue = 0;
            exp_wr    = 0;
            pix_ready = 1'b0;
        end else begin
            eng_done = 1'b0;
            if (rem > 0) begin
                rem--;
                check("eng_x_hold", 32'(eng_x), 32'(cur_idx % WIDTH));
                check("eng_y_hold", 32'(eng_y), 32'(cur_idx / WIDTH));
                if (rem == 0) begin
                    eng_done  = 1'b1;
                    eng_iter  = exp_iter(cur_idx);
                    eng_inset = (cur_idx == cfg_inset);
                end
            end else if (cfg_spur && $urandom_range(0, 2) == 0) begin
                eng_done  = 1'b1;
                eng_iter  = 8'hEE;
                eng_inset = 1'($urandom_range(0, 1));
            end
            if (eng_start) begin
                check("issue_while_valid", 32'(pix_valid), 32'd0);
                check("eng_x", 32'(eng_x), 32'(exp_issue % WIDTH));
                check("eng_y", 32'(eng_y), 32'(exp_issue / WIDTH));
                cur_idx = exp_issue;
                exp_issue++;
                rem = (cfg_lat == 0) ? int'($urandom_range(1, 20)) : cfg_lat;
            end
            if (pend) check("valid_held", 32'(pix_valid), 32'd1);
            if (pix_valid) begin
                check("pix_addr", 32'(pix_addr), 32'(exp_wr));
                check("pix_rgb", 32'(pix_rgb), 32'(exp_rgb(exp_wr)));
                if (cfg_stall_pix == -2) begin
                    pix_ready = 1'($urandom_range(0, 1));
                end else if (exp_wr == cfg_stall_pix && stall_left > 0) begin
                    pix_ready = 1'b0;
                    stall_left--;
                end else begin
                    pix_ready = 1'b1;
                end
                pend = !pix_ready;
                if (pix_ready) exp_wr++;
            end else begin
                pix_ready = (cfg_stall_pix == -2) ? 1'($urandom_range(0, 1)) : 1'b1;
                pend      = 1'b0;
            end
            if (frame_done) fd_count++;
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_busy"},       32'(busy), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_eng_start"},  32'(eng_start), 32'd0);
        check({tag, "_eng_x"},      32'(eng_x), 32'd0);
        check({tag, "_eng_y"},      32'(eng_y), 32'd0);
        check({tag, "_cc_iter"},    32'(cc_iteration), 32'd0);
        check({tag, "_cc_inset"},   32'(cc_ismandelbrot), 32'd0);
        check({tag, "_pix_valid"},  32'(pix_valid), 32'd0);
        check({tag, "_pix_addr"},   32'(pix_addr), 32'd0);
        check({tag, "_pix_rgb"},    32'(pix_rgb), 32'd0);
    endtask

    task automatic run_frame(input vec_t t);
        int cyc;
        cfg_lat       = t.lat;
        cfg_stall_pix = t.stall_pix;
        stall_left    = t.stall_len;
        cfg_spur      = t.spur;
        seed          = t.rand_seed ? int'($urandom_range(0, 255)) : 0;
        cfg_inset     = (t.inset == -3) ? int'($urandom_range(0, NPIX - 1)) : t.inset;
        exp_issue     = 0;
        exp_wr        = 0;
        pend          = 1'b0;
        fd_count      = 0;
        @(negedge clk);
        check("idle_before_start", 32'(busy), 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!frame_done && cyc < 3000) begin
            start = t.abuse && (cyc == 10);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("frame_done_seen", 32'(frame_done), 32'd1);
        if (t.exp_cycles != 0) check("frame_cycles", 32'(cyc), 32'(t.exp_cycles));
        check("busy_at_done", 32'(busy), 32'd1);
        start = t.abuse;
        @(negedge clk);
        start = 1'b0;
        check("frame_done_single", 32'(frame_done), 32'd0);
        check("busy_dropped", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        check("stays_idle", 32'(busy), 32'd0);
        check("frame_done_count", 32'(fd_count), 32'd1);
        check("pixels_written", 32'(exp_wr), 32'(NPIX));
    endtask

    initial begin
        int g;
        vecs[0] = '{1, -1, 0, -1, 1'b0, 1'b0, 1'b0, 33};
        vecs[1] = '{1, -1, 0,  6, 1'b0, 1'b0, 1'b0, 33};
        vecs[2] = '{1,  3, 5, -1, 1'b0, 1'b0, 1'b0, 38};
        vecs[3] = '{4,  2, 2, -1, 1'b1, 1'b0, 1'b0, 59};
        vecs[4] = '{1, -1, 0, -1, 1'b0, 1'b1, 1'b1, 33};
        vecs[5] = '{0, -1, 0, -3, 1'b1, 1'b1, 1'b0, 0};
        vecs[6] = '{0, -2, 0, -3, 1'b1, 1'b1, 1'b0, 0};
        vecs[7] = '{0, -2, 0, -1, 1'b1, 1'b1, 1'b1, 0};

        rst           = 1'b1;
        start         = 1'b0;
        eng_done      = 1'b0;
        eng_iter      = 8'd0;
        eng_inset     = 1'b0;
        pix_ready     = 1'b0;
        cfg_lat       = 1;
        cfg_stall_pix = -1;
        cfg_inset     = -1;
        cfg_spur      = 1'b0;
        seed          = 0;
        stall_left    = 0;
        rem           = 0;
        fd_count      = 0;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;

        for (int v = 0; v < NV; v++) begin
            run_frame(vecs[v]);
        end

        // Abort a frame mid-WAIT with a two-cycle reset, then render cleanly.
        cfg_lat       = 20;
        cfg_stall_pix = -1;
        cfg_inset     = -1;
        cfg_spur      = 1'b0;
        seed          = 0;
        exp_issue     = 0;
        exp_wr        = 0;
        fd_count      = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        g = 0;
        while (exp_issue < 3 && g < 500) begin
            @(negedge clk);
            g++;
        end
        check("reached_pixel2_wait", 32'(g < 500), 32'd1);
        repeat (5) @(negedge clk);
        check("busy_in_wait", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset("rst_cycle1");
        @(negedge clk);
        rst = 1'b0;
        check_reset("rst_cycle2");
        repeat (30) @(negedge clk);
        check("no_done_after_abort", 32'(fd_count), 32'd0);
        check("idle_after_abort", 32'(busy), 32'd0);
        run_frame(vecs[0]);
        run_frame(vecs[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mandel_pixel_sequencer.md
# mandel_pixel_sequencer

Frame-level controller for the Mandelbrot render path. On a start pulse it scans every pixel of the frame in raster order, launches the iteration engine per pixel, and captures the engine's iteration count and in-set flag. It presents them to the color converter, registers the resulting 24-bit RGB, and hands each pixel to the frame-buffer writer over a valid/ready handshake. It sits between the top-level control and the engine → color converter → frame-buffer datapath, and is the only block that sequences them.

## Interface
Parameters:
- WIDTH, 160, pixels per line (≥2, ≤1024)
- HEIGHT, 120, lines per frame (≥1, ≤512)
- ADDR_W, 15, frame-buffer address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  single-cycle request to render one frame; ignored unless in IDLE
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after the last pixel is accepted
- eng_start  out  1  one-cycle pulse launching the iteration engine
- eng_x  out  10  pixel column for the engine, stable from eng_start until eng_done
- eng_y  out  9  pixel row for the engine, same stability rule
- eng_done  in  1  engine result valid (one-cycle pulse)
- eng_iter  in  8  iteration count, sampled when eng_done=1
- eng_inset  in  1  point did not escape, sampled when eng_done=1
- cc_iteration  out  8  registered iteration to the color converter
- cc_ismandelbrot  out  1  registered in-set flag to the color converter
- cc_rgb  in  24  color converter output, combinational from cc_* ports
- pix_valid  out  1  pixel write request
- pix_ready  in  1  frame-buffer writer accepts when pix_valid & pix_ready
- pix_addr  out  ADDR_W  linear address y*WIDTH + x
- pix_rgb  out  24  registered {R,G,B}

## Operation
- States: IDLE, ISSUE, WAIT, CONVERT, WRITE, DONE.
- IDLE: x=y=addr=0. start=1 → ISSUE.
- ISSUE (1 cycle): eng_start=1, eng_x=x, eng_y=y → WAIT.
- WAIT: hold until eng_done=1; on that edge latch eng_iter→cc_iteration and eng_inset→cc_ismandelbrot → CONVERT. eng_done outside WAIT is ignored.
- CONVERT (1 cycle): converter settles; at end of cycle latch cc_rgb→pix_rgb and addr→pix_addr → WRITE.
- WRITE: pix_valid=1; pix_addr and pix_rgb held stable until handshake. On pix_valid & pix_ready:
  - Not last pixel: x increments; at x=WIDTH-1, x wraps to 0 and y increments; addr increments by 1 → ISSUE.
  - Last pixel (x=WIDTH-1, y=HEIGHT-1) → DONE.
- DONE (1 cycle): frame_done=1 → IDLE. start in DONE is ignored.
- Counters never exceed WIDTH-1 / HEIGHT-1; addr never exceeds WIDTH*HEIGHT-1. No multiplier: addr is a running counter.
- start while busy: no effect, no queuing.
- rst asserted in any state, including mid-handshake: next edge → IDLE, frame abandoned, no frame_done.

## Timing
- Reset values: busy=0, frame_done=0, eng_start=0, eng_x=0, eng_y=0, cc_iteration=0, cc_ismandelbrot=0, pix_valid=0, pix_addr=0, pix_rgb=0.
- start sampled at edge N → eng_start high in cycle N+1.
- Per pixel, engine done in the cycle after eng_start and pix_ready held high: ISSUE 1 + WAIT 1 + CONVERT 1 + WRITE 1 = 4 cycles.
- Engine latency L cycles (done L cycles after eng_start): 3+L cycles per pixel. Each stall cycle of pix_ready adds 1.
- frame_done asserts the cycle after the last handshake. busy drops the cycle after that.
- pix_valid, once high, stays high until accepted; it is never withdrawn except by rst.

## Test plan
- Reset: assert rst 2 cycles mid-WAIT → all outputs at reset values next cycle; start then renders from pixel (0,0).
- Small frame WIDTH=4, HEIGHT=2, engine returns iter=x+4y, inset=0 after 1 cycle, pix_ready=1 → 8 writes, addr 0..7, pix_rgb={iter,iter,iter}, frame_done at cycle 33 after start, single pulse.
- In-set pixel: engine returns inset=1, iter=200 for (2,1) → pix_addr=6, pix_rgb=24'h000000; other pixels unaffected.
- Backpressure: pix_ready low 5 cycles on pixel 3 → pix_valid, pix_addr=3, pix_rgb stable all 5 cycles; no eng_start issued until accepted; frame takes 5 extra cycles.
- Variable engine latency 1..20 cycles plus spurious eng_done in ISSUE/WRITE → spurious pulses ignored; outputs match the latched results; coordinates wrap (3,0)→(0,1).
- start during busy and in DONE → ignored; exactly one frame_done; a second start after IDLE renders a second complete frame.
